// File: rtl/soc_bb_sram_arbiter.sv
// Round-robin arbiter sharing one Blackbone SRAM port among NUM_MASTERS requesters.
// Optional macro SOC_BB_ARB_LOCK_EN adds m_lock_i to suppress the burst limit.
module soc_bb_sram_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int BURST_MAX   = 8
) (
  input  logic                      bb_clk_i,
  input  logic                      bb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_din_i,
`ifdef SOC_BB_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]    m_lock_i,
`endif
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  output logic [NUM_MASTERS-1:0]    m_rvalid_o,
  output logic [DW-1:0]             m_dout_o,
  output logic [AW-1:0]             bb_addr_o,
  output logic [DW-1:0]             bb_din_o,
  output logic                      bb_en_o,
  output logic                      bb_we_o,
  input  logic [DW-1:0]             bb_dout_i
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
  localparam logic [OW-1:0] OWN_RST = OW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [OW-1:0]           owner;
  logic [CW-1:0]           beat_cnt;
  logic [NUM_MASTERS-1:0]  rvalid;
  logic [NUM_MASTERS-1:0]  gnt;
  logic [OW-1:0]           next_owner;
  logic [OW-1:0]           idx;
  logic                    found;
  logic                    own_req;
  logic                    own_we;
  logic                    beat;
  logic                    locked;
  logic                    at_limit;
  logic                    rotate;
  logic                    any_req;
  int unsigned             oi;

  assign oi       = 32'(owner);
  assign own_req  = m_req_i[owner];
  assign own_we   = m_we_i[owner];
  assign any_req  = |m_req_i;
  assign at_limit = (beat_cnt == CNT_LAST);

`ifdef SOC_BB_ARB_LOCK_EN
  assign locked = m_lock_i[owner];
`else
  assign locked = 1'b0;
`endif

  // Grant follows the owner's request while an owner is installed.
  always_comb begin
    gnt = '0;
    if (state == GRANT) gnt[owner] = own_req;
  end

  assign beat    = |gnt;
  assign rotate  = ~own_req | (beat & at_limit & ~locked);
  assign m_gnt_o = gnt;
  assign bb_en_o = beat;
  assign bb_we_o = beat & own_we;

  // Bus lines follow the owner's slices; parked at zero when idle.
  always_comb begin
    bb_addr_o = '0;
    bb_din_o  = '0;
    if (state == GRANT) begin
      bb_addr_o = m_addr_i[oi*AW +: AW];
      bb_din_o  = m_din_i[oi*DW +: DW];
    end
  end

  // First requester searching upward from owner+1; owner itself is last.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = OW'((oi + 32'(k)) % 32'(NUM_MASTERS));
      if (!found && m_req_i[idx]) begin
        next_owner = idx;
        found      = 1'b1;
      end
    end
  end

  // Arbitration FSM: owner selection and per-grant beat counting.
  always_ff @(posedge bb_clk_i or posedge bb_rst_i) begin
    if (bb_rst_i) begin
      state    <= IDLE;
      owner    <= OWN_RST;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rotate) begin
            beat_cnt <= '0;
            if (any_req) owner <= next_owner;
            else         state <= IDLE;
          end else if (beat && !(locked && at_limit)) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read beats return rvalid to their issuer one cycle later.
  always_ff @(posedge bb_clk_i or posedge bb_rst_i) begin
    if (bb_rst_i) rvalid <= '0;
    else          rvalid <= own_we ? '0 : gnt;
  end

  assign m_rvalid_o = rvalid;
  assign m_dout_o   = (|rvalid) ? bb_dout_i : '0;

endmodule

// File: tb/tb_soc_bb_sram_arbiter.sv
// Self-checking bench for soc_bb_sram_arbiter.
// Vector table, corner sequences and randomized run against a reference model.
module tb_soc_bb_sram_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BM = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N-1:0]  lock;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] din  [N];
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] din_p;
  logic [DW-1:0] dout_in;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rvalid;
  logic [DW-1:0] dout;
  logic [AW-1:0] bb_addr;
  logic [DW-1:0] bb_din;
  logic          bb_en;
  logic          bb_we;

  int checks;
  int errors;

  int m_owner;
  int m_cnt;
  bit m_active;
  int m_rv;
  logic [N-1:0] last_gnt;

  always_comb begin
    addr_p = '0;
    din_p  = '0;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW] = addr[i];
      din_p[i*DW +: DW]  = din[i];
    end
  end

  soc_bb_sram_arbiter #(
    .NUM_MASTERS(N), .DW(DW), .AW(AW), .BURST_MAX(BM)
  ) dut (
    .bb_clk_i   (clk),
    .bb_rst_i   (rst),
    .m_req_i    (req),
    .m_we_i     (we),
    .m_addr_i   (addr_p),
    .m_din_i    (din_p),
`ifdef SOC_BB_ARB_LOCK_EN
    .m_lock_i   (lock),
`endif
    .m_gnt_o    (gnt),
    .m_rvalid_o (rvalid),
    .m_dout_o   (dout),
    .bb_addr_o  (bb_addr),
    .bb_din_o   (bb_din),
    .bb_en_o    (bb_en),
    .bb_we_o    (bb_we),
    .bb_dout_i  (dout_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_owner  = N - 1;
    m_cnt    = 0;
    m_active = 0;
    m_rv     = -1;
  endtask

  // Inputs are set just after a negedge; sample, check, advance model.
  task automatic cycle();
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    bit           ebeat;
    bit           ewe;
    bit           lim;
    bit           lk;
    int           nrv;
    #1;
    eg = '0;
    if (m_active && req[m_owner]) eg[m_owner] = 1'b1;
    ebeat = (eg != '0);
    ewe   = ebeat && we[m_owner];
    erv   = '0;
    if (m_rv >= 0) erv[m_rv] = 1'b1;
    last_gnt = gnt;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("en", 64'(bb_en), 64'(ebeat));
    chk("we", 64'(bb_we), 64'(ewe));
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("dout", 64'(dout), (m_rv >= 0) ? 64'(dout_in) : 64'd0);
    if (ebeat) begin
      chk("addr", 64'(bb_addr), 64'(addr[m_owner]));
      chk("din", 64'(bb_din), 64'(din[m_owner]));
    end
`ifdef SOC_BB_ARB_LOCK_EN
    lk = lock[m_owner];
`else
    lk = 0;
`endif
    nrv = (ebeat && !we[m_owner]) ? m_owner : -1;
    if (!m_active) begin
      if (req != '0) begin
        m_owner  = pick(m_owner, req);
        m_cnt    = 0;
        m_active = 1;
      end
    end else begin
      lim = ebeat && (m_cnt + 1 >= BM) && !lk;
      if (!req[m_owner] || lim) begin
        m_cnt = 0;
        if (req != '0) m_owner = pick(m_owner, req);
        else           m_active = 0;
      end else if (ebeat) begin
        m_cnt++;
      end
    end
    m_rv = nrv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req  = '0;
    we   = '0;
    lock = '0;
    rst  = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_en", 64'(bb_en), 64'd0);
    chk("rst_we", 64'(bb_we), 64'd0);
    chk("rst_addr", 64'(bb_addr), 64'd0);
    chk("rst_din", 64'(bb_din), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  we;
    logic [N-1:0]  gnt;
    logic          we_o;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [N-1:0]  rv;
  } vec_t;

  vec_t vt [11];

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    req     = '0;
    we      = '0;
    lock    = '0;
    dout_in = '0;
    addr[0] = 32'h100;
    addr[1] = 32'h200;
    addr[2] = 32'h40;
    addr[3] = 32'h300;
    din[0]  = 32'h11111111;
    din[1]  = 32'h22222222;
    din[2]  = 32'hDEADBEEF;
    din[3]  = 32'h33333333;
    model_reset();

    vt[0]  = '{4'b0001, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0000};
    vt[1]  = '{4'b0001, 4'b0000, 4'b0001, 0, 32'h100, 32'h11111111, 4'b0000};
    vt[2]  = '{4'b0000, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0001};
    vt[3]  = '{4'b0100, 4'b0100, 4'b0000, 0, 32'h0,   32'h0,        4'b0000};
    vt[4]  = '{4'b0100, 4'b0100, 4'b0100, 1, 32'h40,  32'hDEADBEEF, 4'b0000};
    vt[5]  = '{4'b0000, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0000};
    vt[6]  = '{4'b0110, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0000};
    vt[7]  = '{4'b0110, 4'b0000, 4'b0010, 0, 32'h200, 32'h22222222, 4'b0000};
    vt[8]  = '{4'b0100, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0010};
    vt[9]  = '{4'b0100, 4'b0000, 4'b0100, 0, 32'h40,  32'hDEADBEEF, 4'b0000};
    vt[10] = '{4'b0000, 4'b0000, 4'b0000, 0, 32'h0,   32'h0,        4'b0100};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      req     = vt[i].req;
      we      = vt[i].we;
      dout_in = 32'hA5A50000 | 32'(i);
      #1;
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vt[i].gnt));
      chk($sformatf("vec%0d_rv", i), 64'(rvalid), 64'(vt[i].rv));
      chk($sformatf("vec%0d_dout", i), 64'(dout),
          (vt[i].rv != '0) ? 64'(dout_in) : 64'd0);
      if (vt[i].gnt != '0) begin
        chk($sformatf("vec%0d_addr", i), 64'(bb_addr), 64'(vt[i].addr));
        chk($sformatf("vec%0d_din", i), 64'(bb_din), 64'(vt[i].din));
        chk($sformatf("vec%0d_we", i), 64'(bb_we), 64'(vt[i].we_o));
      end
      @(negedge clk);
    end

    // Burst limit: M1 gets exactly BM beats, then M2 with no bubble.
    do_reset();
    req = 4'b0110;
    cycle();
    for (int i = 0; i <= BM; i++) begin
      dout_in = $urandom;
      cycle();
      chk($sformatf("burst_gnt%0d", i), 64'(last_gnt),
          (i < BM) ? 64'b0010 : 64'b0100);
    end

    // All four hold requests: BM beats each in order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    cycle();
    for (int i = 0; i < 4 * BM + 1; i++) begin
      dout_in = $urandom;
      cycle();
      chk($sformatf("rr_gnt%0d", i), 64'(last_gnt),
          64'(1 << ((i / BM) % N)));
    end

    // Reset during M0's third read beat.
    do_reset();
    req = 4'b0001;
    cycle();
    cycle();
    cycle();
    #1;
    chk("mid_gnt_pre", 64'(gnt), 64'b0001);
    chk("mid_rv_pre", 64'(rvalid), 64'b0001);
    rst = 1'b1;
    #1;
    chk("mid_gnt_rst", 64'(gnt), 64'd0);
    chk("mid_rv_rst", 64'(rvalid), 64'd0);
    chk("mid_en_rst", 64'(bb_en), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    chk("mid_post0", 64'(last_gnt), 64'd0);
    cycle();
    chk("mid_post1", 64'(last_gnt), 64'b0001);
    req = '0;
    cycle();
    cycle();

`ifdef SOC_BB_ARB_LOCK_EN
    // Locked owner keeps the port past BM, then hands off after one idle.
    do_reset();
    lock = 4'b0001;
    req  = 4'b0011;
    cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk($sformatf("lock_gnt%0d", i), 64'(last_gnt), 64'b0001);
    end
    req  = 4'b0010;
    lock = '0;
    cycle();
    chk("lock_idle", 64'(last_gnt), 64'd0);
    cycle();
    chk("lock_m1", 64'(last_gnt), 64'b0010);
    req = '0;
    cycle();
    cycle();
`endif

    // Randomized traffic with persistent requests.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(7) == 0) req[m] = ~req[m];
        we[m]   = $urandom_range(1) == 1;
        addr[m] = $urandom;
        din[m]  = $urandom;
`ifdef SOC_BB_ARB_LOCK_EN
        lock[m] = $urandom_range(3) == 0;
`endif
      end
      dout_in = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
